// File: rtl/sha_256_padder_if.sv
// sha_256_padder_if: word-in / block-out handshake bundle of the SHA-256 padder.
// master drives message words and consumes blocks; slave is the padder.
interface sha_256_padder_if;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] block_data;
    logic         block_last;
    logic         block_valid;
    logic         block_ready;

    modport master (
        output in_data, in_bytes, in_last, in_valid, block_ready,
        input  in_ready, block_data, block_last, block_valid
    );

    modport slave (
        input  in_data, in_bytes, in_last, in_valid, block_ready,
        output in_ready, block_data, block_last, block_valid
    );
endinterface

// File: rtl/sha_256_padder.sv
// sha_256_padder: packs a 32-bit big-endian word stream into SHA-256 padded 512-bit blocks.
// Define SHA_PADDER_CHECK_EN to add a sticky err output for illegal words and length wrap.
module sha_256_padder #(
    parameter int LEN_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
`ifdef SHA_PADDER_CHECK_EN
    output logic            err,
`endif
    sha_256_padder_if.slave bus
);

    typedef enum logic [1:0] {S_FILL, S_OUT, S_PAD_EXTRA} state_t;

    state_t            state;
    logic [0:15][31:0] words;
    logic [3:0]        idx;
    logic [LEN_W-1:0]  len;
    logic              ready_q;
    logic              extra_pend;
    logic              extra_marker;

    logic              accept;
    logic              out_hs;
    logic [2:0]        nbytes;
    logic [LEN_W-1:0]  len_next;
    logic [4:0]        marker_idx;
    logic [31:0]       last_word;

    // ready_q is only ever set in S_FILL, so it doubles as the fill-state qualifier.
    assign accept         = ena & ready_q & bus.in_valid;
    assign out_hs         = ena & bus.block_valid & bus.block_ready;
    assign bus.in_ready   = ena & ready_q;
    assign bus.block_data = words;

    // Non-final words and out-of-range counts always contribute four bytes.
    assign nbytes     = (bus.in_last && bus.in_bytes <= 3'd4) ? bus.in_bytes : 3'd4;
    assign marker_idx = (nbytes == 3'd4) ? {1'b0, idx} + 5'd1 : {1'b0, idx};

`ifdef SHA_PADDER_CHECK_EN
    logic len_wrap;
    assign {len_wrap, len_next} = {1'b0, len} + (LEN_W+1)'({nbytes, 3'b000});
`else
    assign len_next = len + LEN_W'({nbytes, 3'b000});
`endif

    // NOTE: every path assigns last_word (default arm included), so no latch is inferred.
    always_comb begin
        case (nbytes)
            3'd0:    last_word = 32'h8000_0000;
            3'd1:    last_word = {bus.in_data[31:24], 24'h80_0000};
            3'd2:    last_word = {bus.in_data[31:16], 16'h8000};
            3'd3:    last_word = {bus.in_data[31:8], 8'h80};
            default: last_word = bus.in_data;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_FILL;
            // NOTE: the block buffer is reset too, since it is the visible block_data output.
            words           <= '0;
            idx             <= '0;
            len             <= '0;
            ready_q         <= 1'b0;
            extra_pend      <= 1'b0;
            extra_marker    <= 1'b0;
            bus.block_valid <= 1'b0;
            bus.block_last  <= 1'b0;
        end else if (ena) begin
            case (state)
                S_FILL: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        words[idx] <= bus.in_last ? last_word : bus.in_data;
                        idx        <= idx + 4'd1;
                        len        <= len_next;
                        if (bus.in_last) begin
                            ready_q         <= 1'b0;
                            state           <= S_OUT;
                            bus.block_valid <= 1'b1;
                            if (nbytes == 3'd4 && idx != 4'd15)
                                words[idx + 4'd1] <= 32'h8000_0000;
                            if (marker_idx <= 5'd13) begin
                                words[14:15]   <= 64'(len_next);
                                bus.block_last <= 1'b1;
                            end else begin
                                bus.block_last <= 1'b0;
                                extra_pend     <= 1'b1;
                                extra_marker   <= (marker_idx == 5'd16);
                            end
                        end else if (idx == 4'd15) begin
                            ready_q         <= 1'b0;
                            state           <= S_OUT;
                            bus.block_valid <= 1'b1;
                            bus.block_last  <= 1'b0;
                        end
                    end
                end
                S_OUT: begin
                    if (out_hs) begin
                        bus.block_valid <= 1'b0;
                        if (bus.block_last)
                            len <= '0;
                        if (extra_pend) begin
                            state <= S_PAD_EXTRA;
                        end else begin
                            // Cleared buffer supplies the zero fill of the next block.
                            state   <= S_FILL;
                            idx     <= '0;
                            words   <= '0;
                            ready_q <= 1'b1;
                        end
                    end
                end
                S_PAD_EXTRA: begin
                    words           <= '0;
                    words[0]        <= extra_marker ? 32'h8000_0000 : 32'h0;
                    words[14:15]    <= 64'(len);
                    extra_pend      <= 1'b0;
                    extra_marker    <= 1'b0;
                    bus.block_last  <= 1'b1;
                    bus.block_valid <= 1'b1;
                    state           <= S_OUT;
                end
                default: state <= S_FILL;
            endcase
        end
    end

`ifdef SHA_PADDER_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err <= 1'b0;
        else if (accept && ((!bus.in_last && bus.in_bytes != 3'd4) ||
                            bus.in_bytes > 3'd4 || len_wrap))
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sha_256_padder.sv
// tb_sha_256_padder: directed and random messages through sha_256_padder, checked
// against a byte-level SHA-256 padding model (bytes + 0x80 + zeros + 64-bit length).
module tb_sha_256_padder;

    typedef byte unsigned bytes_t[$];

    localparam logic [511:0] ABC_BLK   = {32'h6162_6380, {14{32'h0}}, 32'h0000_0018};
    localparam logic [511:0] EMPTY_BLK = {32'h8000_0000, 480'h0};
    localparam logic [511:0] B56_LAST  = {480'h0, 32'h0000_01C0};
    localparam logic [511:0] B64_LAST  = {32'h8000_0000, 448'h0, 32'h0000_0200};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ena = 1'b0;
    logic rand_mode = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int blocks_seen = 0;
    logic [511:0] exp_data_q[$];
    logic         exp_last_q[$];
    logic [511:0] last_blk = '0;

    sha_256_padder_if bif();

`ifdef SHA_PADDER_CHECK_EN
    logic err;
`endif

    sha_256_padder #(.LEN_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
`ifdef SHA_PADDER_CHECK_EN
        .err (err),
`endif
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: pad the whole message as bytes, then cut into 64-byte blocks.
    task automatic model_message(input bytes_t msg);
        bytes_t       p;
        logic [63:0]  bits;
        logic [511:0] blk;
        int           nblk;
        p = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < 64; i++) blk[511 - 8*i -: 8] = p[64*b + i];
            exp_data_q.push_back(blk);
            exp_last_q.push_back(b == nblk - 1);
        end
    endtask

    task automatic send_word(input logic [31:0] data, input logic [2:0] nb, input logic last);
        int waited = 0;
        if (rand_mode && $urandom_range(0, 3) == 0) begin
            bif.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        bif.in_data  = data;
        bif.in_bytes = nb;
        bif.in_last  = last;
        bif.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bif.in_ready) break;
            waited++;
            if (waited > 2000) begin
                check("in_timeout", 512'(waited), 512'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
    endtask

    // A byte count that is a multiple of 4 may end either on a full last word
    // or with an extra zero-byte last word; both must pad identically.
    task automatic send_message(input bytes_t msg);
        int          n;
        int          full;
        int          rem;
        bit          zero_tail;
        logic [31:0] w;
        n    = msg.size();
        full = n / 4;
        rem  = n % 4;
        model_message(msg);
        zero_tail = (rem == 0) && (n == 0 || $urandom_range(0, 1) == 1);
        for (int i = 0; i < full; i++) begin
            w = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
            send_word(w, 3'd4, !zero_tail && rem == 0 && i == full - 1);
        end
        if (rem != 0 || zero_tail) begin
            w = $urandom();
            for (int j = 0; j < rem; j++) w[31 - 8*j -: 8] = msg[4*full + j];
            send_word(w, 3'(rem), 1'b1);
        end
    endtask

    task automatic random_msg(input int n, output bytes_t msg);
        msg = {};
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic drain();
        int t = 0;
        while (exp_data_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check("drain_left", 512'(exp_data_q.size()), 512'(0));
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            ena             = ($urandom_range(0, 7) != 0);
            bif.block_ready = ($urandom_range(0, 2) != 0);
        end
    end

    always @(negedge clk) begin
        if (rst && ena && bif.block_valid && bif.block_ready) begin
            if (exp_data_q.size() == 0) begin
                check("unexpected_block", 512'(1), 512'(0));
            end else begin
                check("block_data", bif.block_data, exp_data_q.pop_front());
                check("block_last", 512'(bif.block_last), 512'(exp_last_q.pop_front()));
            end
            last_blk = bif.block_data;
            blocks_seen++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bytes_t msg;
        int     lens[14] = '{0, 3, 4, 52, 55, 56, 59, 60, 63, 64, 65, 119, 120, 128};

        bif.in_data     = '0;
        bif.in_bytes    = '0;
        bif.in_last     = 1'b0;
        bif.in_valid    = 1'b0;
        bif.block_ready = 1'b0;
        ena             = 1'b1;
        rst             = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",    512'(bif.in_ready),    512'(0));
        check("rst_block_valid", 512'(bif.block_valid), 512'(0));
        check("rst_block_last",  512'(bif.block_last),  512'(0));
        check("rst_block_data",  bif.block_data,        '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("fill_in_ready", 512'(bif.in_ready), 512'(1));

        // "abc" held under backpressure for five cycles.
        msg = '{8'h61, 8'h62, 8'h63};
        send_message(msg);
        check("abc_latency_valid", 512'(bif.block_valid), 512'(1));
        for (int c = 0; c < 5; c++) begin
            check("bp_block_data", bif.block_data, ABC_BLK);
            check("bp_in_ready", 512'(bif.in_ready), 512'(0));
            @(posedge clk);
            #1;
        end
        bif.block_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_drop", 512'(bif.block_valid), 512'(0));
        check("bp_in_ready_back", 512'(bif.in_ready), 512'(1));
        check("abc_block", last_blk, ABC_BLK);
        drain();

        msg = {};
        send_message(msg);
        drain();
        check("empty_block", last_blk, EMPTY_BLK);

        random_msg(56, msg);
        send_message(msg);
        drain();
        check("len56_last_block", last_blk, B56_LAST);

        random_msg(64, msg);
        send_message(msg);
        drain();
        check("len64_last_block", last_blk, B64_LAST);

        // Reset in the middle of a message discards it entirely.
        for (int i = 0; i < 7; i++) send_word($urandom(), 3'd4, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_in_ready",    512'(bif.in_ready),    512'(0));
        check("midrst_block_valid", 512'(bif.block_valid), 512'(0));
        check("midrst_block_last",  512'(bif.block_last),  512'(0));
        check("midrst_block_data",  bif.block_data,        '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        msg = '{8'h61, 8'h62, 8'h63};
        send_message(msg);
        drain();
        check("abc_after_reset", last_blk, ABC_BLK);

        // Random lengths, random ena and block_ready.
        rand_mode = 1'b1;
        for (int m = 0; m < 40; m++) begin
            if ($urandom_range(0, 1) == 1)
                random_msg(lens[$urandom_range(0, 13)], msg);
            else
                random_msg(int'($urandom_range(0, 200)), msg);
            send_message(msg);
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #2;
        ena             = 1'b1;
        bif.block_ready = 1'b1;
        drain();

`ifdef SHA_PADDER_CHECK_EN
        check("err_clear", 512'(err), 512'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
